pipe_branch_predictor: RTL
==========================

// Module: pipe_branch_predictor
// PURPOSE
//   Dynamic branch predictor for the 5-stage RV32 pipeline; replaces static predict-not-taken.
//   F stage: direct-mapped BTB + saturating counters give a next-PC prediction for PCF.
//   E stage: resolved branches/jumps update the table; mispredicts produce flush and redirect.
//   Also keeps performance counters for resolved branches and mispredicts.
// PARAMETERS
//   XLEN     32  address/data width
//   INDEX_W  4   log2 of entry count (ENTRIES = 2**INDEX_W); legal range 1..8
//   CNT_W    2   saturating counter width; legal range 1..4
// PORTS
//   clk           in   1        rising-edge clock
//   rst           in   1        synchronous, active-high reset
//   PCF           in   XLEN     fetch PC; bits [1:0] ignored
//   PredTakenF    out  1        prediction for PCF is taken
//   NextPCF       out  XLEN     predicted next PC: PredTargetF if PredTakenF, else PCF+4
//   PredTargetF   out  XLEN     BTB target on hit, else PCF+4
//   UpdateE       in   1        valid branch/jump resolving in E; caller drives 0 for bubbles
//   PCE           in   XLEN     PC of the resolving instruction
//   JumpE         in   1        instruction is JAL/JALR (always taken)
//   TakenE        in   1        actual outcome
//   TargetE       in   XLEN     actual taken target
//   PredTakenE    in   1        PredTakenF piped down with the instruction
//   PredTargetE   in   XLEN     PredTargetF piped down with the instruction
//   MispredictE   out  1        flush F/D and redirect this cycle
//   RedirectPCE   out  XLEN     correct PC: TargetE if TakenE, else PCE+4
//   BranchCount   out  32       number of UpdateE cycles
//   MispredCount  out  32       number of MispredictE cycles
// BEHAVIOUR
//   Table: ENTRIES x {valid, jump, tag[XLEN-2-INDEX_W], target[XLEN], cnt[CNT_W]}.
//   Index is PC[INDEX_W+1:2]; tag is PC[XLEN-1:INDEX_W+2].
//   Lookup (combinational on PCF): hit = valid & tag match.
//     PredTakenF = hit & (jump | cnt[CNT_W-1]).
//   MispredictE = UpdateE & ((PredTakenE != TakenE) | (TakenE & PredTargetE != TargetE)).
//     Purely combinational, zero latency.
//   Update (posedge, UpdateE=1, rst=0), at index of PCE:
//     - Hit, TakenE=1: cnt saturating +1 (stops at 2**CNT_W-1); target<=TargetE; jump<=JumpE.
//     - Hit, TakenE=0: cnt saturating -1 (stops at 0); target unchanged.
//     - Miss, TakenE=1: allocate and overwrite any occupant: valid=1, tag, target=TargetE,
//       jump=JumpE, cnt=2**(CNT_W-1) (weakly taken).
//     - Miss, TakenE=0: no table write.
//     - Counters: BranchCount += 1; MispredCount += MispredictE. Both wrap modulo 2**32.
//   Same-cycle lookup and update on the same index: lookup sees pre-update contents
//     (no bypass). The new contents are visible from the next cycle.
//   Reset (synchronous, 1 cycle): all valid=0, jump=0, cnt=2**(CNT_W-1)-1
//     (weakly not-taken), BranchCount=MispredCount=0. Target/tag contents are don't-care.
//   Reset asserted together with UpdateE: the update is discarded and reset wins.
//   Outputs after reset with UpdateE=0: PredTakenF=0, NextPCF=PredTargetF=PCF+4, MispredictE=0.
//   Reset mid-operation loses all history; the pipeline flushes separately.
//   All PC+4 adds wrap modulo 2**XLEN.
// TESTING
//   1 Reset, then PCF=0x100 -> PredTakenF=0, NextPCF=0x104. Both counts read 0.
//   2 Update PCE=0x100, TakenE=1, TargetE=0x80, PredTakenE=0:
//     -> MispredictE=1, RedirectPCE=0x80; next cycle PCF=0x100 -> PredTakenF=1, NextPCF=0x80.
//   3 Same branch not-taken twice (default params):
//     -> cnt 10->01->00; PredTakenF=0 after the first update.
//     -> RedirectPCE=0x104 whenever MispredictE=1.
//   4 JAL at 0x200 -> 0x300 allocated; then 4 not-taken updates at 0x200:
//     -> PredTakenF stays 1 (jump bit set).
//   5 Alias: PCE=0x100 and PCE=0x140 (INDEX_W=4, same index 0) both taken:
//     -> the last writer owns the entry; PCF=0x100 then misses -> NextPCF=0x104.
//   6 Assert rst while UpdateE=1 on a taken branch:
//     -> the table is empty after reset and counts=0; sweep CNT_W=1 and 3, INDEX_W=1 and 8 for saturation.

Source files
------------

// File: rtl/pipe_branch_predictor_if.sv
// Interface between the RV32 pipeline and the dynamic branch predictor.
// The fetch-stage lookup and the execute-stage resolution share one bundle.
// The pipeline is the master, and the predictor is the slave.
interface pipe_branch_predictor_if #(
    parameter int XLEN = 32
);
    // Fetch-stage lookup
    logic [XLEN-1:0] PCF;
    logic            PredTakenF;
    logic [XLEN-1:0] NextPCF;
    logic [XLEN-1:0] PredTargetF;

    // Execute-stage resolution
    logic            UpdateE;
    logic [XLEN-1:0] PCE;
    logic            JumpE;
    logic            TakenE;
    logic [XLEN-1:0] TargetE;
    logic            PredTakenE;
    logic [XLEN-1:0] PredTargetE;
    logic            MispredictE;
    logic [XLEN-1:0] RedirectPCE;

    // Performance counters
    logic [31:0]     BranchCount;
    logic [31:0]     MispredCount;

    modport master (
        output PCF, UpdateE, PCE, JumpE, TakenE, TargetE, PredTakenE, PredTargetE,
        input  PredTakenF, NextPCF, PredTargetF, MispredictE, RedirectPCE,
               BranchCount, MispredCount
    );

    modport slave (
        input  PCF, UpdateE, PCE, JumpE, TakenE, TargetE, PredTakenE, PredTargetE,
        output PredTakenF, NextPCF, PredTargetF, MispredictE, RedirectPCE,
               BranchCount, MispredCount
    );
endinterface

// File: rtl/pipe_branch_predictor.sv
// Dynamic branch predictor built from a direct-mapped BTB with saturating counters.
// The fetch stage does a combinational lookup on PCF.
// The execute stage trains the table, and it also flags mispredicts with a redirect PC.
// The lookup sees the contents from before any same-cycle update, because there is no bypass.
module pipe_branch_predictor #(
    parameter int XLEN    = 32,
    parameter int INDEX_W = 4,
    parameter int CNT_W   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    pipe_branch_predictor_if.slave  bp
);
    localparam int ENTRIES = 1 << INDEX_W;
    localparam int TAG_W   = XLEN - 2 - INDEX_W;

    // Counter encodings. MSB set means the entry predicts taken.
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1) << (CNT_W - 1);
    localparam logic [CNT_W-1:0] CNT_WNT = CNT_WT - CNT_W'(1);

    logic              r_valid  [ENTRIES];
    logic              r_jump   [ENTRIES];
    logic [TAG_W-1:0]  r_tag    [ENTRIES];
    logic [XLEN-1:0]   r_target [ENTRIES];
    logic [CNT_W-1:0]  r_cnt    [ENTRIES];
    logic [31:0]       r_branch_cnt;
    logic [31:0]       r_mispred_cnt;

    logic [INDEX_W-1:0] w_idx_f;
    logic [TAG_W-1:0]   w_tag_f;
    logic [XLEN-1:0]    w_pc4_f;
    logic               w_hit_f;
    logic               w_pred_taken_f;
    logic [XLEN-1:0]    w_pred_target_f;

    logic [INDEX_W-1:0] w_idx_e;
    logic [TAG_W-1:0]   w_tag_e;
    logic               w_hit_e;
    logic               w_mispredict_e;
    logic [XLEN-1:0]    w_redirect_e;

    // Fetch lookup: tag compare, and a taken prediction from the jump bit or the counter MSB
    always_comb begin
        w_idx_f         = bp.PCF[INDEX_W+1:2];
        w_tag_f         = bp.PCF[XLEN-1:INDEX_W+2];
        w_pc4_f         = bp.PCF + XLEN'(4);
        w_hit_f         = r_valid[w_idx_f] && (r_tag[w_idx_f] == w_tag_f);
        w_pred_taken_f  = 1'b0;
        w_pred_target_f = w_pc4_f;
        if (w_hit_f) begin
            w_pred_taken_f  = r_jump[w_idx_f] || r_cnt[w_idx_f][CNT_W-1];
            w_pred_target_f = r_target[w_idx_f];
        end else begin
            w_pred_taken_f  = 1'b0;
            w_pred_target_f = w_pc4_f;
        end
    end

    // Execute resolution: compare the direction and the target, and build the redirect PC
    always_comb begin
        w_idx_e        = bp.PCE[INDEX_W+1:2];
        w_tag_e        = bp.PCE[XLEN-1:INDEX_W+2];
        w_hit_e        = r_valid[w_idx_e] && (r_tag[w_idx_e] == w_tag_e);
        w_mispredict_e = bp.UpdateE &&
                         ((bp.PredTakenE != bp.TakenE) ||
                          (bp.TakenE && (bp.PredTargetE != bp.TargetE)));
        if (bp.TakenE) begin
            w_redirect_e = bp.TargetE;
        end else begin
            w_redirect_e = bp.PCE + XLEN'(4);
        end
    end

    assign bp.PredTakenF   = w_pred_taken_f;
    assign bp.PredTargetF  = w_pred_target_f;
    assign bp.NextPCF      = w_pred_taken_f ? w_pred_target_f : w_pc4_f;
    assign bp.MispredictE  = w_mispredict_e;
    assign bp.RedirectPCE  = w_redirect_e;
    assign bp.BranchCount  = r_branch_cnt;
    assign bp.MispredCount = r_mispred_cnt;

    // Table training and performance counters. Reset clears history and overrides any update.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_jump[i]  <= 1'b0;
                r_cnt[i]   <= CNT_WNT;
            end
            r_branch_cnt  <= 32'd0;
            r_mispred_cnt <= 32'd0;
        end else if (bp.UpdateE) begin
            r_branch_cnt  <= r_branch_cnt + 32'd1;
            r_mispred_cnt <= r_mispred_cnt + 32'(w_mispredict_e);
            if (w_hit_e) begin
                if (bp.TakenE) begin
                    if (r_cnt[w_idx_e] != CNT_MAX) begin
                        r_cnt[w_idx_e] <= r_cnt[w_idx_e] + CNT_W'(1);
                    end
                    r_target[w_idx_e] <= bp.TargetE;
                    r_jump[w_idx_e]   <= bp.JumpE;
                end else if (r_cnt[w_idx_e] != '0) begin
                    r_cnt[w_idx_e] <= r_cnt[w_idx_e] - CNT_W'(1);
                end
            end else if (bp.TakenE) begin
                // A taken miss takes over the slot, whatever was there before
                r_valid[w_idx_e]  <= 1'b1;
                r_tag[w_idx_e]    <= w_tag_e;
                r_target[w_idx_e] <= bp.TargetE;
                r_jump[w_idx_e]   <= bp.JumpE;
                r_cnt[w_idx_e]    <= CNT_WT;
            end
        end
    end
endmodule
